// File: rtl/afh_map_builder_if.sv
// rtl/afh_map_builder_if.sv - update request, hop strobe and active AFH state seen by the hop kernel
interface afh_map_builder_if;
  logic        upd_req;
  logic [79:0] new_chmap;
  logic        hop_sync;
  logic        busy;
  logic        done_p;
  logic        map_err;
  logic [79:0] AFH_channel_map;
  logic [6:0]  AFH_modN;
  logic [6:0]  rd_addr;
  logic [6:0]  rd_data;

  modport master (
    output upd_req, new_chmap, hop_sync, rd_addr,
    input  busy, done_p, map_err, AFH_channel_map, AFH_modN, rd_data
  );

  modport slave (
    input  upd_req, new_chmap, hop_sync, rd_addr,
    output busy, done_p, map_err, AFH_channel_map, AFH_modN, rd_data
  );
endinterface

// File: rtl/afh_map_builder.sv
// rtl/afh_map_builder.sv - scans a 79-channel map into a double-buffered remap table, commits on hop_sync
module afh_map_builder #(
  parameter int NMIN = 20
) (
  input  logic              clk,
  input  logic              rst,
  afh_map_builder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, PEND} state_t;

  state_t      state_q, state_d;
  logic [6:0]  k_q, k_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic        last_q, last_d;
  logic [78:0] shadow_q, shadow_d;
  logic [79:0] map_q, map_d;
  logic [6:0]  modn_q, modn_d;
  logic        valid_q, valid_d;
  logic        bank_q, bank_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [6:0]  tab_q [2][79];
  logic        wr_en;
  logic        commit;
  logic [6:0]  ch;

  // Basic-hop order: all even channels first, then all odd channels.
  always_comb begin
    ch = (k_q <= 7'd39) ? (k_q << 1) : (((k_q - 7'd40) << 1) | 7'd1);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    map_d    = map_q;
    modn_d   = modn_q;
    valid_d  = valid_q;
    bank_d   = bank_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.upd_req) begin
          shadow_d = bus.new_chmap[78:0];
          k_d      = 7'd0;
          wcnt_d   = 7'd0;
          last_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (!last_q) begin
          if (shadow_q[ch]) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + 7'd1;
          end
          if (k_q == 7'd78) last_d = 1'b1;
          else              k_d    = k_q + 7'd1;
        end else if (wcnt_q < 7'(NMIN)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.hop_sync) begin
          commit = 1'b1;
        end else begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (bus.hop_sync) commit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Everything the kernel reads flips in this single update.
    if (commit) begin
      bank_d  = ~bank_q;
      map_d   = {1'b0, shadow_q};
      modn_d  = wcnt_q;
      valid_d = 1'b1;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= 7'd0;
      wcnt_q   <= 7'd0;
      last_q   <= 1'b0;
      shadow_q <= '0;
      map_q    <= {1'b0, {79{1'b1}}};
      modn_q   <= 7'd79;
      valid_q  <= 1'b0;
      bank_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wcnt_q   <= wcnt_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
      map_q    <= map_d;
      modn_q   <= modn_d;
      valid_q  <= valid_d;
      bank_q   <= bank_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Table contents need no reset; table_valid and modN gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) tab_q[~bank_q][wcnt_q] <= ch;
  end

  assign bus.busy            = busy_q;
  assign bus.done_p          = done_q;
  assign bus.map_err         = err_q;
  assign bus.AFH_channel_map = map_q;
  assign bus.AFH_modN        = modn_q;
  assign bus.rd_data         = (valid_q && (bus.rd_addr < modn_q)) ? tab_q[bank_q][bus.rd_addr] : 7'd0;
endmodule

// File: tb/tb_afh_map_builder.sv
// tb/tb_afh_map_builder.sv - scoreboard bench for afh_map_builder
module tb_afh_map_builder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  afh_map_builder_if bus ();
  afh_map_builder #(.NMIN(20)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        err;
    logic [6:0]  modn;
    logic [79:0] map;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [79:0] m_map;
  logic [6:0]  m_modn;
  logic        m_valid;
  logic [6:0]  m_tab [79];
  int          lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_map   = {1'b0, {79{1'b1}}};
    m_modn  = 7'd79;
    m_valid = 1'b0;
  endfunction

  function automatic void model_load(input logic [79:0] m);
    int n = 0;
    for (int c = 0; c < 79; c += 2) if (m[c]) begin m_tab[n] = 7'(c); n++; end
    for (int c = 1; c < 79; c += 2) if (m[c]) begin m_tab[n] = 7'(c); n++; end
    m_map   = {1'b0, m[78:0]};
    m_modn  = 7'(n);
    m_valid = 1'b1;
  endfunction

  task automatic rd(input int a, input logic [6:0] exp, input string tag);
    bus.rd_addr = 7'(a);
    #1;
    chk(tag, 80'(bus.rd_data), 80'(exp));
  endtask

  task automatic sweep(input string tag);
    logic [6:0] e;
    for (int a = 0; a < 80; a++) begin
      e = (m_valid && a < int'(m_modn)) ? m_tab[a] : 7'd0;
      rd(a, e, tag);
    end
    rd(100, 7'd0, tag);
  endtask

  task automatic start_upd(input logic [79:0] m);
    exp_t e;
    int   cnt;
    cnt = $countones(m[78:0]);
    if (cnt < 20) begin
      e.err = 1'b1; e.modn = m_modn; e.map = m_map;
    end else begin
      e.err = 1'b0; e.modn = 7'(cnt); e.map = {1'b0, m[78:0]};
    end
    sb.push_back(e);
    bus.new_chmap = m;
    bus.upd_req   = 1'b1;
    tick();
    bus.upd_req   = 1'b0;
    chk("busy_after_e0", 80'(bus.busy), 80'd1);
  endtask

  task automatic wait_done(input int spur, output int l);
    l = 0;
    for (int i = 1; i <= 300; i++) begin
      if (spur > 0 && (i == spur || i == spur + 40)) begin
        bus.upd_req   = 1'b1;
        bus.new_chmap = '0;
      end
      tick();
      bus.upd_req = 1'b0;
      if (bus.done_p) begin l = i; break; end
    end
    if (l == 0) chk("done_timeout", 80'd0, 80'd1);
  endtask

  task automatic finish_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 80'd0, 80'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_map_err"}, 80'(bus.map_err), 80'(e.err));
    chk({tag, "_modN"}, 80'(bus.AFH_modN), 80'(e.modn));
    chk({tag, "_chmap"}, bus.AFH_channel_map, e.map);
    chk({tag, "_busy"}, 80'(bus.busy), 80'd0);
    if (!e.err) model_load(e.map);
    sweep({tag, "_rd"});
    tick();
    chk({tag, "_done_pulse"}, 80'(bus.done_p), 80'd0);
    chk({tag, "_err_pulse"}, 80'(bus.map_err), 80'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_modN"}, 80'(bus.AFH_modN), 80'd79);
    chk({tag, "_chmap"}, bus.AFH_channel_map, 80'h7FFF_FFFF_FFFF_FFFF_FFFF);
    chk({tag, "_busy"}, 80'(bus.busy), 80'd0);
    chk({tag, "_done"}, 80'(bus.done_p), 80'd0);
    chk({tag, "_err"}, 80'(bus.map_err), 80'd0);
    rd(0, 7'd0, {tag, "_rd0"});
    rd(50, 7'd0, {tag, "_rd50"});
  endtask

  initial begin
    logic [79:0] rnd;
    int          saw;
    rst = 1'b1;
    bus.upd_req = 1'b0;
    bus.new_chmap = '0;
    bus.hop_sync = 1'b0;
    bus.rd_addr = 7'd0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check_reset("reset");

    bus.hop_sync = 1'b1;
    start_upd({80{1'b1}});
    wait_done(0, lat);
    chk("all_latency", 80'(lat), 80'd80);
    chk("all_bit79", 80'(bus.AFH_channel_map[79]), 80'd0);
    rd(0, 7'd0, "all_rd0"); rd(1, 7'd2, "all_rd1"); rd(39, 7'd78, "all_rd39");
    rd(40, 7'd1, "all_rd40"); rd(78, 7'd77, "all_rd78");
    finish_check("all");

    start_upd(80'hF_FFFF);
    wait_done(0, lat);
    chk("low20_modN_const", 80'(bus.AFH_modN), 80'd20);
    rd(0, 7'd0, "low20_rd0"); rd(9, 7'd18, "low20_rd9"); rd(10, 7'd1, "low20_rd10");
    rd(19, 7'd19, "low20_rd19"); rd(20, 7'd0, "low20_rd20");
    finish_check("low20");

    start_upd(80'h7_FFFF);
    wait_done(0, lat);
    chk("rej_latency", 80'(lat), 80'd80);
    chk("rej_modN_const", 80'(bus.AFH_modN), 80'd20);
    finish_check("rej");

    bus.hop_sync = 1'b0;
    rnd = {$urandom(), $urandom(), $urandom()};
    start_upd(rnd | (80'hF_FFFF << 30));
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i % 10 == 0) begin
        chk("pend_busy", 80'(bus.busy), 80'd1);
        chk("pend_done", 80'(bus.done_p), 80'd0);
        chk("pend_modN", 80'(bus.AFH_modN), 80'd20);
        rd(5, 7'd10, "pend_rd5_old");
      end
    end
    bus.hop_sync = 1'b1;
    tick();
    bus.hop_sync = 1'b0;
    chk("pend_commit_done", 80'(bus.done_p), 80'd1);
    finish_check("pend");

    bus.hop_sync = 1'b1;
    start_upd({80{1'b1}});
    for (int i = 1; i < 40; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    model_reset();
    check_reset("midscan_rst");
    saw = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.done_p) saw = 1;
    end
    chk("midscan_no_done", 80'(saw), 80'd0);
    sweep("midscan_rd");

    rnd = {$urandom(), $urandom(), $urandom()};
    start_upd(rnd | 80'hAAAA_AAAA_AA00_0000_0000);
    wait_done(10, lat);
    chk("spur_latency", 80'(lat), 80'd80);
    finish_check("spur");
    chk("sb_drained", 80'(sb.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
